pool_win_feeder: RTL

- Streams a feature map from a synchronous-read buffer into the pooling datapath in 3x3 non-overlapping window order.
- Within each window, elements are read row-major, so the pooling row/column counter sees 9 consecutive valid beats per window.
- Sits between the feature-map SRAM and the pool window counter / max-pool unit.
- One start launches a full frame; done pulses when the frame completes.

---
 rtl/pool_win_feeder_if.sv | 60 ++++++
 rtl/pool_win_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool_win_feeder_if.sv
// ---------------------------------------------------------------------------
// pool_win_feeder_if
//
// Purpose:
//   Bundles the control handshake, feature-map buffer read port and pooling
//   datapath output of pool_win_feeder into one interface.
//
// Signals:
//   start      frame start request (toward the feeder)
//   win_rdy    downstream can accept a full 9-beat window (toward the feeder)
//   mem_rdata  buffer read data, valid one cycle after mem_ren (toward the feeder)
//   mem_ren    buffer read enable (from the feeder)
//   mem_raddr  buffer read address (from the feeder)
//   out_data   pixel to the pooling datapath (from the feeder)
//   out_vld    out_data valid (from the feeder)
//   busy       frame in progress (from the feeder)
//   done       single-cycle frame-complete pulse (from the feeder)
//
// Modports:
//   master  the feeder itself
//   slave   the surrounding system (controller, SRAM, pool datapath)
// ---------------------------------------------------------------------------
interface pool_win_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              start;
    logic              win_rdy;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] out_data;
    logic              out_vld;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  win_rdy,
        input  mem_rdata,
        output mem_ren,
        output mem_raddr,
        output out_data,
        output out_vld,
        output busy,
        output done
    );

    modport slave (
        output start,
        output win_rdy,
        output mem_rdata,
        input  mem_ren,
        input  mem_raddr,
        input  out_data,
        input  out_vld,
        input  busy,
        input  done
    );
endinterface

// File: rtl/pool_win_feeder.sv
// ---------------------------------------------------------------------------
// pool_win_feeder
//
// Purpose:
//   Reads a feature map out of a synchronous-read buffer in 3x3
//   non-overlapping window order (windows in raster order, elements inside a
//   window row-major) and presents the pixels to the pooling datapath. Every
//   window is sent as 9 back-to-back valid beats, so a downstream 9-beat
//   window counter always stays aligned. Gaps appear only between windows,
//   when the downstream side is not ready at a window boundary.
//
// Parameters:
//   IMG_W   feature-map width  (multiple of 3)
//   IMG_H   feature-map height (multiple of 3)
//   DATA_W  pixel width
//   ADDR_W  buffer address width, IMG_W*IMG_H <= 2**ADDR_W
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts a frame without done
//   bus    pool_win_feeder_if.master:
//            start/win_rdy/mem_rdata in, mem_ren/mem_raddr/out_data/
//            out_vld/busy/done out
// ---------------------------------------------------------------------------
module pool_win_feeder #(
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pool_win_feeder_if.master bus
);

    // Window grid dimensions and counter widths.
    localparam int NUM_WC = IMG_W / 3;
    localparam int NUM_WR = IMG_H / 3;
    localparam int WC_W   = (NUM_WC > 1) ? $clog2(NUM_WC) : 1;
    localparam int WR_W   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(NUM_WC - 1);
    localparam logic [WR_W-1:0] WR_LAST = WR_W'(NUM_WR - 1);

    // Address steps: one pixel row, one window row, one window column.
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] WROW_STEP = ADDR_W'(3 * IMG_W);
    localparam logic [ADDR_W-1:0] WCOL_STEP = ADDR_W'(3);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic              r_ren;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_vld;
    logic              r_busy;

    // Position of the element currently on r_raddr (or, outside RUN, of the
    // next window to be issued). c/r index inside the window, wc/wr index the
    // window. The bases hold the address terms so no multiplier is needed:
    //   r_wrBase  = 3*wr*IMG_W
    //   r_rowBase = (3*wr + r)*IMG_W
    //   r_colBase = 3*wc
    logic [1:0]        r_c;
    logic [1:0]        r_r;
    logic [WC_W-1:0]   r_wc;
    logic [WR_W-1:0]   r_wr;
    logic [ADDR_W-1:0] r_wrBase;
    logic [ADDR_W-1:0] r_rowBase;
    logic [ADDR_W-1:0] r_colBase;

    logic [1:0]        w_nextC;
    logic [1:0]        w_nextR;
    logic [WC_W-1:0]   w_nextWc;
    logic [WR_W-1:0]   w_nextWr;
    logic [ADDR_W-1:0] w_nextWrBase;
    logic [ADDR_W-1:0] w_nextRowBase;
    logic [ADDR_W-1:0] w_nextColBase;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [ADDR_W-1:0] w_winAddr;
    logic              w_lastElem;
    logic              w_lastWin;
    logic              w_startOk;

    assign w_lastElem = (r_c == 2'd2) && (r_r == 2'd2);
    assign w_lastWin  = (r_wc == WC_LAST) && (r_wr == WR_LAST);
    assign w_startOk  = (r_state == S_IDLE) && bus.start;

    // First element of the pending window; c and r are zero here, so the
    // row base is also the window-row base.
    assign w_winAddr = r_rowBase + r_colBase;

    // Step the position by one element: c wraps into r, r wraps into wc,
    // wc wraps into wr. After the last window everything wraps back to 0.
    always_comb begin
        w_nextC       = r_c;
        w_nextR       = r_r;
        w_nextWc      = r_wc;
        w_nextWr      = r_wr;
        w_nextWrBase  = r_wrBase;
        w_nextRowBase = r_rowBase;
        w_nextColBase = r_colBase;
        if (r_c != 2'd2) begin
            w_nextC = r_c + 2'd1;
        end else begin
            w_nextC = 2'd0;
            if (r_r != 2'd2) begin
                w_nextR       = r_r + 2'd1;
                w_nextRowBase = r_rowBase + ROW_STEP;
            end else begin
                w_nextR = 2'd0;
                if (r_wc != WC_LAST) begin
                    w_nextWc      = r_wc + WC_W'(1);
                    w_nextColBase = r_colBase + WCOL_STEP;
                    w_nextRowBase = r_wrBase;
                end else begin
                    w_nextWc      = '0;
                    w_nextColBase = '0;
                    if (r_wr != WR_LAST) begin
                        w_nextWr      = r_wr + WR_W'(1);
                        w_nextWrBase  = r_wrBase + WROW_STEP;
                        w_nextRowBase = r_wrBase + WROW_STEP;
                    end else begin
                        w_nextWr      = '0;
                        w_nextWrBase  = '0;
                        w_nextRowBase = '0;
                    end
                end
            end
        end
    end

    assign w_nextAddr = w_nextRowBase + w_nextColBase + ADDR_W'(w_nextC);

    // Position counters: cleared when a frame is accepted, stepped once per
    // issued read while in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c       <= '0;
            r_r       <= '0;
            r_wc      <= '0;
            r_wr      <= '0;
            r_wrBase  <= '0;
            r_rowBase <= '0;
            r_colBase <= '0;
        end else if (w_startOk) begin
            r_c       <= '0;
            r_r       <= '0;
            r_wc      <= '0;
            r_wr      <= '0;
            r_wrBase  <= '0;
            r_rowBase <= '0;
            r_colBase <= '0;
        end else if (r_state == S_RUN) begin
            r_c       <= w_nextC;
            r_r       <= w_nextR;
            r_wc      <= w_nextWc;
            r_wr      <= w_nextWr;
            r_wrBase  <= w_nextWrBase;
            r_rowBase <= w_nextRowBase;
            r_colBase <= w_nextColBase;
        end
    end

    // Frame FSM. win_rdy is only looked at in WAIT and on the last element of
    // a window, so a window that has started always runs its 9 reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ren   <= 1'b0;
            r_raddr <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ren <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                        r_raddr <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.win_rdy) begin
                        r_state <= S_RUN;
                        r_ren   <= 1'b1;
                        r_raddr <= w_winAddr;
                    end
                end
                S_RUN: begin
                    r_raddr <= w_nextAddr;
                    if (w_lastElem) begin
                        if (w_lastWin) begin
                            r_state <= S_DRAIN;
                            r_ren   <= 1'b0;
                        end else if (!bus.win_rdy) begin
                            r_state <= S_WAIT;
                            r_ren   <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ren   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read data returns one cycle after the enable, so valid is the enable
    // delayed by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
        end else begin
            r_vld <= r_ren;
        end
    end

    assign bus.mem_ren   = r_ren;
    assign bus.mem_raddr = r_raddr;
    assign bus.out_data  = bus.mem_rdata;
    assign bus.out_vld   = r_vld;
    assign bus.busy      = r_busy;
    assign bus.done      = (r_state == S_DONE);

endmodule
